// File: rtl/spi_master_mx.sv
// SPI master with a queued {slave-select, data} transmit FIFO.
// Word width, slave count, FIFO depth and SCLK divider width are parameters.
// CPOL, CPHA and the divider are taken from the inputs when a frame starts.
module spi_master_mx #(
   parameter int DATA_W     = 8,
   parameter int NUM_SS     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 8,
   localparam int SEL_W     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              Clk_i,
   input  logic              Rst_i,
   input  logic [DATA_W-1:0] ToXmit_i,
   input  logic [SEL_W-1:0]  SsSel_i,
   input  logic              Strobe_i,
   input  logic              Cpol_i,
   input  logic              Cpha_i,
   input  logic [DIV_W-1:0]  ClkDiv_i,
   output logic              XmitFull_o,
   output logic              Busy_o,
   output logic              Ready_o,
   output logic [DATA_W-1:0] Rcvd_o,
   output logic              Err_o,
   output logic              Sclk_o,
   output logic              Mosi_o,
   input  logic              Miso_i,
   output logic [NUM_SS-1:0] Ss_no
);

   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int ENTRY_W   = SEL_W + DATA_W;
   localparam int EDGE_W    = $clog2(2 * DATA_W);
   localparam int LAST_EDGE = 2 * DATA_W - 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

   state_t               state_q, state_d;
   logic                 strobe_q, push_req, sel_ok, push_ok, pop;
   logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [ENTRY_W-1:0]   head;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 full_q, err_q;
   logic [SEL_W-1:0]     sel_q;
   logic                 cpha_q;
   logic [DIV_W-1:0]     div_q, cnt_q;
   logic [EDGE_W-1:0]    edge_q;
   logic                 tick, last_edge, sample_now;
   logic [DATA_W-1:0]    tx_sr, rx_sr, rcvd_q;
   logic                 sclk_q, mosi_q;
   logic [NUM_SS-1:0]    ss_sel_n;

   assign push_req   = Strobe_i & ~strobe_q;
   assign sel_ok     = (32'(SsSel_i) < NUM_SS);
   assign pop        = (state_q == S_IDLE) && (count_q != '0);
   // A full FIFO still accepts a push in the cycle it is popped.
   assign push_ok    = push_req && sel_ok && (!full_q || pop);
   assign head       = fifo_mem[rd_ptr_q];
   assign tick       = (cnt_q == div_q);
   assign last_edge  = (edge_q == EDGE_W'(LAST_EDGE));
   // Even edge index = leading edge; CPHA selects which edge samples.
   assign sample_now = ~edge_q[0] ^ cpha_q;

   assign XmitFull_o = full_q;
   assign Err_o      = err_q;
   assign Rcvd_o     = rcvd_q;
   assign Mosi_o     = mosi_q;

   // Occupancy after this cycle's push and pop.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      count_d = count_q;
      if (push_ok && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push_ok)
         count_d = count_q - 1'b1;
   end

   // FIFO storage; written only on an accepted push.
   always_ff @(posedge Clk_i) begin
      // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
      if (push_ok)
         fifo_mem[wr_ptr_q] <= {SsSel_i, ToXmit_i};
   end

   // FSM state register.
   always_ff @(posedge Clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // FSM next-state logic: each of SETUP and HOLD lasts one half-period.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (count_q != '0)     state_d = S_SETUP;
         S_SETUP: if (tick)              state_d = S_XFER;
         S_XFER:  if (tick && last_edge) state_d = S_HOLD;
         S_HOLD:  if (tick)              state_d = S_GAP;
         S_GAP:                          state_d = S_IDLE;
         default:                        state_d = S_IDLE;
      endcase
   end

   // One-hot active-low select for the latched slave index.
   always_comb begin
      ss_sel_n = '1;
      for (int i = 0; i < NUM_SS; i++)
         ss_sel_n[i] = (32'(sel_q) != i);
   end

   // FSM outputs: selects, busy and ready derived from the current state.
   always_comb begin
      Busy_o  = 1'b0;
      Ready_o = 1'b0;
      Sclk_o  = sclk_q;
      Ss_no   = '1;
      unique case (state_q)
         S_IDLE:                  Sclk_o = Cpol_i;
         S_SETUP, S_XFER, S_HOLD: begin
            Busy_o = 1'b1;
            Ss_no  = ss_sel_n;
         end
         S_GAP:                   Ready_o = 1'b1;
         default:                 ;
      endcase
   end

   // FIFO bookkeeping, config latch, SCLK timing and the shift registers.
   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         strobe_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         err_q    <= 1'b0;
         sel_q    <= '0;
         cpha_q   <= 1'b0;
         div_q    <= '0;
         cnt_q    <= '0;
         edge_q   <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rcvd_q   <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         strobe_q <= Strobe_i;
         err_q    <= push_req & ~push_ok;
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(FIFO_DEPTH));
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + 1'b1;

         // Start of frame: take the head entry and freeze the bus mode.
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            sel_q    <= head[ENTRY_W-1 -: SEL_W];
            tx_sr    <= head[DATA_W-1:0];
            cpha_q   <= Cpha_i;
            div_q    <= ClkDiv_i;
            sclk_q   <= Cpol_i;
            if (!Cpha_i)
               mosi_q <= head[DATA_W-1];
         end

         // Half-period counter runs only while the slave is selected.
         if (state_q == S_SETUP || state_q == S_XFER || state_q == S_HOLD)
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
         else
            cnt_q <= '0;

         if (state_q != S_XFER)
            edge_q <= '0;
         else if (tick) begin
            edge_q <= edge_q + 1'b1;
            sclk_q <= ~sclk_q;
            if (sample_now)
               rx_sr <= {rx_sr[DATA_W-2:0], Miso_i};
            else begin
               mosi_q <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
               if (cpha_q)
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
               else
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
         end

         // Received word becomes visible in the GAP cycle.
         if (state_q == S_HOLD && tick)
            rcvd_q <= rx_sr;
      end
   end

endmodule

// File: tb/tb_spi_master_mx.sv
// Self-checking bench for spi_master_mx: an 8-bit/2-slave instance driven by
// a behavioural SPI slave, a 16-bit/4-slave loopback instance and a 3-slave
// instance for the out-of-range select.
module tb_spi_master_mx;

   logic       tbClk = 1'b0;
   logic       Rst = 1'b1;
   logic       Cpol = 1'b0, Cpha = 1'b0;
   logic [7:0] ClkDiv = 8'd1;

   // 8-bit, 2-slave instance
   logic [7:0] tx0 = '0, Rcvd0;
   logic       sel0 = 1'b0, stb0 = 1'b0;
   logic       Full0, Busy0, Ready0, Err0, Sclk0, Mosi0, Miso0;
   logic [1:0] Ss0;

   // 16-bit, 4-slave instance
   logic [15:0] tx1 = '0, Rcvd1;
   logic [1:0]  sel1 = '0;
   logic        stb1 = 1'b0;
   logic        Full1, Busy1, Ready1, Err1, Sclk1, Mosi1;
   logic [3:0]  Ss1;

   // 8-bit, 3-slave instance
   logic [7:0] Rcvd2;
   logic [1:0] sel2 = '0;
   logic       stb2 = 1'b0;
   logic       Full2, Busy2, Ready2, Err2, Sclk2, Mosi2;
   logic [2:0] Ss2;

   always #5 tbClk = ~tbClk;

   // behavioural slave on instance 0
   logic       loop0 = 1'b0, slv_miso = 1'b0;
   logic [7:0] slv_word = '0;
   assign Miso0 = loop0 ? Mosi0 : slv_miso;

   spi_master_mx #(.DATA_W(8), .NUM_SS(2), .FIFO_DEPTH(4), .DIV_W(8)) u0 (
      .Clk_i(tbClk), .Rst_i(Rst), .ToXmit_i(tx0), .SsSel_i(sel0), .Strobe_i(stb0),
      .Cpol_i(Cpol), .Cpha_i(Cpha), .ClkDiv_i(ClkDiv), .XmitFull_o(Full0),
      .Busy_o(Busy0), .Ready_o(Ready0), .Rcvd_o(Rcvd0), .Err_o(Err0),
      .Sclk_o(Sclk0), .Mosi_o(Mosi0), .Miso_i(Miso0), .Ss_no(Ss0));

   spi_master_mx #(.DATA_W(16), .NUM_SS(4), .FIFO_DEPTH(4), .DIV_W(8)) u1 (
      .Clk_i(tbClk), .Rst_i(Rst), .ToXmit_i(tx1), .SsSel_i(sel1), .Strobe_i(stb1),
      .Cpol_i(Cpol), .Cpha_i(Cpha), .ClkDiv_i(ClkDiv), .XmitFull_o(Full1),
      .Busy_o(Busy1), .Ready_o(Ready1), .Rcvd_o(Rcvd1), .Err_o(Err1),
      .Sclk_o(Sclk1), .Mosi_o(Mosi1), .Miso_i(Mosi1), .Ss_no(Ss1));

   spi_master_mx #(.DATA_W(8), .NUM_SS(3), .FIFO_DEPTH(4), .DIV_W(8)) u2 (
      .Clk_i(tbClk), .Rst_i(Rst), .ToXmit_i(tx0), .SsSel_i(sel2), .Strobe_i(stb2),
      .Cpol_i(Cpol), .Cpha_i(Cpha), .ClkDiv_i(ClkDiv), .XmitFull_o(Full2),
      .Busy_o(Busy2), .Ready_o(Ready2), .Rcvd_o(Rcvd2), .Err_o(Err2),
      .Sclk_o(Sclk2), .Mosi_o(Mosi2), .Miso_i(Mosi2), .Ss_no(Ss2));

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         sel;
      int         len;
      int         rises;
      logic [7:0] rx;
      int         gap;
      bit         multi;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic       sel;
      logic       cpol;
      logic       cpha;
      logic [7:0] div;
      logic       loop;
      logic [7:0] slv;
      logic [7:0] exp_rcvd;
      int         exp_len;
   } vec_t;

   frame_t     obs_q[$];
   logic [7:0] rdy_q[$];
   bit         mon_en = 1'b0;

   // Bus monitor + slave for instance 0: records each select-low window.
   bit         act = 1'b0;
   logic       sclk_prev = 1'b0;
   int         nxt = 0, hi_cnt = 0;
   frame_t     cur;
   always @(negedge tbClk) begin
      if (mon_en) begin
         if (Ss0 !== 2'b11) begin
            if (!act) begin
               act       = 1'b1;
               cur.len   = 0;
               cur.rises = 0;
               cur.rx    = '0;
               cur.gap   = hi_cnt;
               cur.multi = 1'b0;
               cur.sel   = (Ss0 == 2'b10) ? 0 : 1;
               hi_cnt    = 0;
               if (!Cpha) begin
                  slv_miso = slv_word[7];
                  nxt      = 6;
               end else
                  nxt = 7;
            end
            if (Ss0 == 2'b00) cur.multi = 1'b1;
            cur.len++;
            if (Sclk0 !== sclk_prev) begin
               if (Sclk0) cur.rises++;
               // leading edge = leaving the idle level
               if ((Sclk0 !== Cpol) ^ Cpha)
                  cur.rx = {cur.rx[6:0], Mosi0};
               else if (nxt >= 0) begin
                  slv_miso = slv_word[nxt];
                  nxt--;
               end
            end
         end else begin
            if (act) begin
               act = 1'b0;
               obs_q.push_back(cur);
            end
            hi_cnt++;
         end
         if (Ready0) rdy_q.push_back(Rcvd0);
      end
      sclk_prev = Sclk0;
   end

   // Monitor for instance 1 and activity flag for instance 2.
   int          len1 = 0, rise1 = 0, rdy1 = 0;
   bit          bad1 = 1'b0, act2 = 1'b0;
   logic        sclk1_prev = 1'b0;
   logic [15:0] rcvd1 = '0;
   always @(negedge tbClk) begin
      if (mon_en) begin
         if (Ss1 !== 4'hF) begin
            len1++;
            if (Ss1 !== 4'b0111) bad1 = 1'b1;
            if (Sclk1 && !sclk1_prev) rise1++;
         end
         if (Ready1) begin
            rdy1++;
            rcvd1 = Rcvd1;
         end
         if (Ss2 !== 3'b111 || Busy2 || Ready2) act2 = 1'b1;
      end
      sclk1_prev = Sclk1;
   end

   // Pulse the strobe for one cycle; entered and left just after a falling edge.
   task automatic push0(input logic [7:0] d, input logic s);
      tx0  = d;
      sel0 = s;
      stb0 = 1'b1;
      @(negedge tbClk);
      stb0 = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int t = 0;
      while ((obs_q.size() < n || rdy_q.size() < n) && t < 3000) begin
         @(negedge tbClk);
         t++;
      end
      check("frames_seen", obs_q.size(), n);
      check("ready_seen", rdy_q.size(), n);
   endtask

   task automatic compare_frame(input logic [7:0] d, input int sel, input int len,
                                input logic [7:0] rc, input bit chk_gap);
      frame_t     fr;
      logic [7:0] r;
      if (obs_q.size() == 0 || rdy_q.size() == 0) return;
      fr = obs_q.pop_front();
      r  = rdy_q.pop_front();
      check("frame_sel", fr.sel, sel);
      check("ss_low_cycles", fr.len, len);
      check("sclk_rises", fr.rises, 8);
      check("mosi_word", fr.rx, d);
      check("rcvd", r, rc);
      check("single_ss_low", fr.multi, 0);
      if (chk_gap) check("gap_ge_2", fr.gap >= 2, 1);
   endtask

   task automatic run_vec(input vec_t v);
      Cpol     = v.cpol;
      Cpha     = v.cpha;
      ClkDiv   = v.div;
      loop0    = v.loop;
      slv_word = v.slv;
      #1;
      check("sclk_idle_level", Sclk0, v.cpol);
      push0(v.data, v.sel);
      check("ss_high_after_push", Ss0, 2'b11);
      @(negedge tbClk);
      check("ss_low_latency", Ss0, v.sel ? 2'b01 : 2'b10);
      check("busy_in_frame", Busy0, 1);
      wait_frames(1);
      compare_frame(v.data, v.sel, v.exp_len, v.exp_rcvd, 1'b0);
      repeat (3) @(negedge tbClk);
      check("rcvd_holds", Rcvd0, v.exp_rcvd);
   endtask

   vec_t tbl[7];
   vec_t rv;
   int   edges, t, n_rdy;
   logic prev;

   initial begin
      // {data, sel, cpol, cpha, div, loop, slave word, expected Rcvd, expected select-low cycles}
      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'h3C, 8'h3C, 36};
      tbl[1] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 8'h00, 8'h81, 36};
      tbl[2] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 8'h00, 8'h81, 36};
      tbl[3] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 8'h00, 8'h81, 36};
      tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'hFF, 8'hFF, 18};
      tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 8'h00, 8'h00, 72};
      tbl[6] = '{8'h96, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 8'h69, 8'h69, 54};

      // reset state
      Rst  = 1'b1;
      Cpol = 1'b1;
      repeat (3) @(negedge tbClk);
      check("rst_ss", Ss0, 2'b11);
      check("rst_busy", Busy0, 0);
      check("rst_ready", Ready0, 0);
      check("rst_err", Err0, 0);
      check("rst_full", Full0, 0);
      check("rst_rcvd", Rcvd0, 0);
      check("rst_mosi", Mosi0, 0);
      check("rst_sclk_cpol", Sclk0, 1);
      Cpol = 1'b0;
      #1;
      check("idle_sclk_live", Sclk0, 0);
      Rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge tbClk);

      // directed table
      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // randomized frames against the reference rules
      for (int i = 0; i < 12; i++) begin
         rv.data     = 8'($urandom);
         rv.sel      = 1'($urandom_range(0, 1));
         rv.cpol     = 1'($urandom_range(0, 1));
         rv.cpha     = 1'($urandom_range(0, 1));
         rv.div      = 8'($urandom_range(0, 3));
         rv.loop     = 1'($urandom_range(0, 1));
         rv.slv      = 8'($urandom);
         rv.exp_rcvd = rv.loop ? rv.data : rv.slv;
         rv.exp_len  = (2 * 8 + 2) * (int'(rv.div) + 1);
         run_vec(rv);
      end

      // back-to-back burst filling the FIFO
      Cpol   = 1'b0;
      Cpha   = 1'b0;
      ClkDiv = 8'd1;
      loop0  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         push0(8'(i), i[0]);
         if (i == 4) check("full_after_4", Full0, 0);
         if (i < 5) @(negedge tbClk);
      end
      check("full_after_5", Full0, 1);
      check("no_err_on_accept", Err0, 0);
      @(negedge tbClk);
      push0(8'h06, 1'b0);
      check("err_on_full", Err0, 1);
      @(negedge tbClk);
      check("err_one_cycle", Err0, 0);
      check("full_held", Full0, 1);
      wait_frames(5);
      for (int i = 1; i <= 5; i++)
         compare_frame(8'(i), i % 2, 36, 8'(i), i > 1);
      repeat (10) @(negedge tbClk);
      check("no_extra_frame", obs_q.size(), 0);
      check("burst_full_clear", Full0, 0);
      check("burst_idle", Busy0, 0);

      // out-of-range slave select on the 3-slave instance
      sel2 = 2'd3;
      stb2 = 1'b1;
      @(negedge tbClk);
      stb2 = 1'b0;
      check("err_bad_sel", Err2, 1);
      repeat (10) @(negedge tbClk);
      check("no_frame_bad_sel", act2, 0);
      check("bad_sel_err_clear", Err2, 0);

      // reset in the middle of a frame
      loop0 = 1'b1;
      push0(8'h33, 1'b0);
      edges = 0;
      t     = 0;
      prev  = Sclk0;
      while (edges < 4 && t < 200) begin
         @(negedge tbClk);
         t++;
         if (Sclk0 !== prev) edges++;
         prev = Sclk0;
      end
      check("abort_edge_reached", edges, 4);
      n_rdy = rdy_q.size();
      Rst   = 1'b1;
      @(negedge tbClk);
      check("abort_ss", Ss0, 2'b11);
      check("abort_busy", Busy0, 0);
      check("abort_ready", Ready0, 0);
      Rst = 1'b0;
      repeat (20) @(negedge tbClk);
      check("abort_no_ready", rdy_q.size(), n_rdy);
      check("abort_fifo_empty", Busy0, 0);
      obs_q.delete();
      rdy_q.delete();
      rv = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 8'h5A, 36};
      run_vec(rv);

      // 16-bit, 4-slave, fastest SCLK
      Cpol   = 1'b0;
      Cpha   = 1'b0;
      ClkDiv = 8'd0;
      tx1    = 16'hBEEF;
      sel1   = 2'd3;
      stb1   = 1'b1;
      @(negedge tbClk);
      stb1 = 1'b0;
      t    = 0;
      while (rdy1 < 1 && t < 500) begin
         @(negedge tbClk);
         t++;
      end
      check("w16_ready_count", rdy1, 1);
      check("w16_rcvd", rcvd1, 16'hBEEF);
      check("w16_ss_low_cycles", len1, 34);
      check("w16_sclk_rises", rise1, 16);
      check("w16_ss_pattern", bad1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
